// File: rtl/pipelined_main_memory.sv
// pipelined_main_memory: fixed-latency in-order word memory, one request per cycle, snapshot reads
module pipelined_main_memory #(
    parameter int    LATENCY   = 4,
    parameter int    ADDR_W    = 16,
    parameter int    DATA_W    = 16,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy
);
    localparam int WORDS = 2 ** (ADDR_W - 1);
    logic [DATA_W-1:0] mem [WORDS];
    logic [LATENCY-1:0] v;
    logic [DATA_W-1:0] d [LATENCY];
    logic [ADDR_W-2:0] idx;
    logic unused_addr_lsb;
    assign idx = addr[ADDR_W-1:1];
    assign unused_addr_lsb = addr[0];
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("LATENCY must be in 1..8");
    end
    always_ff @(posedge clk) begin
        if (enable && wr) mem[idx] <= data_in;
    end
    // Invalid stages carry zero data so data_out is zero without masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < LATENCY; i++) d[i] <= '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
            v[0] <= 1'b0;
            d[0] <= '0;
            if (enable && !wr) begin
                v[0] <= 1'b1;
                d[0] <= mem[idx];
            end
        end
    end
    assign data_out   = d[LATENCY-1];
    assign data_valid = v[LATENCY-1];
    assign busy       = |v;
    a_enable_known: assert property (@(posedge clk) !$isunknown(enable))
        else $warning("enable is X; treated as no request");
endmodule
